// File: rtl/fp16_pkg.sv
// Shared binary16 field widths, constants, unpacked-operand type and helpers.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS   = 15;

  localparam logic [15:0] FP16_ONE     = 16'h3C00;
  localparam logic [15:0] FP16_NEG_ONE = 16'hBC00;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam logic [15:0] FP16_PINF    = 16'h7C00;

  // Operand split into fields; mant carries the hidden bit (zero when flushed).
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W:0]   mant;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } fp16_unpacked_t;

  // Subnormals are flushed to signed zero here, so downstream never sees them.
  function automatic fp16_unpacked_t fp16_unpack(input logic [15:0] x);
    fp16_unpacked_t u;
    u.sign    = x[15];
    u.exp     = x[14:10];
    u.is_zero = (x[14:10] == 5'd0);
    u.is_inf  = (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
    u.is_nan  = (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    u.mant    = u.is_zero ? 11'd0 : {1'b1, x[9:0]};
    return u;
  endfunction

  // Leading-zero count of a 14-bit magnitude; returns 14 for an all-zero input.
  function automatic logic [3:0] lzc14(input logic [13:0] v);
    logic [3:0] n;
    logic       found;
    n     = 4'd0;
    found = 1'b0;
    for (int i = 13; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 4'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fp16_round_pack.sv
// Rounds a {1.frac, guard, round, sticky} mantissa and packs binary16 with over/underflow.
// Latency: combinational. Backpressure: none.
// Rounding: FP16_RNE_EN defined gives ties-to-even, otherwise truncation toward zero.
module fp16_round_pack
  import fp16_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] exp,
  input  logic [13:0]       mant,
  output logic [15:0]       res
);

  logic              round_up;
  logic [11:0]       rounded;
  logic [9:0]        frac;
  logic signed [9:0] exp_r;

  // Round the 11-bit significand, renormalize on carry-out, then clamp the exponent.
  always_comb begin
    round_up = 1'b0;
`ifdef FP16_RNE_EN
    round_up = mant[2] & (mant[1] | mant[0] | mant[3]);
`endif
    rounded = {1'b0, mant[13:3]} + {11'd0, round_up};
    if (rounded[11]) begin
      frac  = rounded[10:1];
      exp_r = exp + 10'sd1;
    end else begin
      frac  = rounded[9:0];
      exp_r = exp;
    end
    if (!mant[13])
      res = {sign, 15'd0};
    else if (exp_r >= 10'sd31)
      res = {sign, FP16_PINF[14:0]};
    else if (exp_r <= 10'sd0)
      res = {sign, 15'd0};
    else
      res = {sign, exp_r[4:0], frac};
  end

endmodule

// File: rtl/fp16_arith.sv
// Binary16 add/multiply with one registered result; FTZ inputs, shared round/pack stage.
// Latency: 1 cycle, one op per cycle. Backpressure: none, valid pulses once per en.
// Rounding selected by FP16_RNE_EN (ties-to-even when defined, truncate otherwise).
module fp16_arith
  import fp16_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         valid
);

  fp16_unpacked_t    ua, ub, big, sml;
  logic [21:0]       prod;
  logic signed [9:0] mul_exp, add_exp, rp_exp;
  logic [13:0]       mul_mant, add_mant, rp_mant;
  logic [13:0]       big_ext, small_ext;
  logic [27:0]       shifted;
  logic [4:0]        diff;
  logic [14:0]       sum;
  logic [3:0]        lz;
  logic              add_sign, rp_sign;
  logic [15:0]       rp_res, calc;

  assign ua = fp16_unpack(a);
  assign ub = fp16_unpack(b);

  // Multiply path: 11x11 product, at most one normalizing shift, GRS from the low bits.
  always_comb begin
    prod     = 22'(ua.mant) * 22'(ub.mant);
    mul_exp  = $signed({5'd0, ua.exp}) + $signed({5'd0, ub.exp}) - 10'sd15
             + (prod[21] ? 10'sd1 : 10'sd0);
    mul_mant = prod[21] ? {prod[21:9], |prod[8:0]} : {prod[20:8], |prod[7:0]};
  end

  // Add path: order by magnitude, align with sticky, add/subtract, normalize by LZC.
  always_comb begin
    if ({ua.exp, ua.mant} >= {ub.exp, ub.mant}) begin
      big = ua;
      sml = ub;
    end else begin
      big = ub;
      sml = ua;
    end
    diff    = big.exp - sml.exp;
    big_ext = {big.mant, 3'b000};
    shifted = {sml.mant, 3'b000, 14'd0} >> diff;
    // Past 13 places the whole small operand lands below the sticky position.
    if (sml.is_zero)
      small_ext = 14'd0;
    else if (diff > 5'd13)
      small_ext = 14'd1;
    else
      small_ext = shifted[27:14] | {13'd0, |shifted[13:0]};
    if (ua.sign ^ ub.sign)
      sum = {1'b0, big_ext} - {1'b0, small_ext};
    else
      sum = {1'b0, big_ext} + {1'b0, small_ext};
    lz = lzc14(sum[13:0]);
    if (sum[14]) begin
      add_mant = {sum[14:2], sum[1] | sum[0]};
      add_exp  = $signed({5'd0, big.exp}) + 10'sd1;
    end else begin
      add_mant = sum[13:0] << lz;
      add_exp  = $signed({5'd0, big.exp}) - $signed({6'd0, lz});
    end
    // An exact zero sum is +0 unless both operands were -0.
    add_sign = (sum == 15'd0) ? (ua.sign & ub.sign) : big.sign;
  end

  // Select the finite path feeding the shared round/pack stage.
  always_comb begin
    rp_sign = op ? (ua.sign ^ ub.sign) : add_sign;
    rp_exp  = op ? mul_exp : add_exp;
    rp_mant = op ? mul_mant : add_mant;
  end

  fp16_round_pack u_round_pack (
    .sign (rp_sign),
    .exp  (rp_exp),
    .mant (rp_mant),
    .res  (rp_res)
  );

  // NaN and infinity handling overrides the finite datapath.
  always_comb begin
    calc = rp_res;
    if (ua.is_nan || ub.is_nan) begin
      calc = FP16_QNAN;
    end else if (op) begin
      if ((ua.is_inf && ub.is_zero) || (ub.is_inf && ua.is_zero))
        calc = FP16_QNAN;
      else if (ua.is_inf || ub.is_inf)
        calc = {ua.sign ^ ub.sign, FP16_PINF[14:0]};
    end else begin
      if (ua.is_inf && ub.is_inf && (ua.sign != ub.sign))
        calc = FP16_QNAN;
      else if (ua.is_inf)
        calc = {ua.sign, FP16_PINF[14:0]};
      else if (ub.is_inf)
        calc = {ub.sign, FP16_PINF[14:0]};
    end
  end

  // Output register: reset wins over en; result holds when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= en;
      if (en) result <= calc;
    end
  end

endmodule

// File: tb/tb_fp16_arith.sv
// Directed table-driven bench for fp16_arith plus hold/reset sequences.
// Latency: checks one cycle after each enabled edge. Backpressure: none.
// Rounding-sensitive vectors follow FP16_RNE_EN.
module tb_fp16_arith;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;
  logic        valid;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  fp16_arith #(.W(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .op     (op),
    .a      (a),
    .b      (b),
    .result (result),
    .valid  (valid)
  );

  always #5 clk = ~clk;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic add_vec(input logic o, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] e);
    vec_t v;
    v.op  = o;
    v.a   = x;
    v.b   = y;
    v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    add_vec(1'b1, 16'h3C00, 16'hBC00, 16'hBC00); // 1 * -1
    add_vec(1'b0, 16'h3C00, 16'hBC00, 16'h0000); // 1 + -1 = +0
    add_vec(1'b0, 16'h3C00, 16'h3C00, 16'h4000); // 1 + 1
    add_vec(1'b1, 16'h3800, 16'h4000, 16'h3C00); // 0.5 * 2
    add_vec(1'b1, 16'h7BFF, 16'h4000, 16'h7C00); // overflow
    add_vec(1'b1, 16'h7C00, 16'h0000, 16'h7E00); // inf * 0
    add_vec(1'b0, 16'h7C00, 16'hFC00, 16'h7E00); // inf + -inf
    add_vec(1'b0, 16'h3C00, 16'h1000, 16'h3C00); // tie, even kept
    add_vec(1'b0, 16'h3C00, 16'h1400, 16'h3C01); // exact lsb add
    add_vec(1'b0, 16'h8000, 16'h8000, 16'h8000); // -0 + -0
    add_vec(1'b0, 16'h8000, 16'h0000, 16'h0000); // -0 + +0
    add_vec(1'b1, 16'h7C01, 16'h3C00, 16'h7E00); // NaN * 1
    add_vec(1'b0, 16'h3C00, 16'hFE00, 16'h7E00); // 1 + NaN
    add_vec(1'b1, 16'h7C00, 16'hC000, 16'hFC00); // inf * -2
    add_vec(1'b0, 16'h3C00, 16'hFC00, 16'hFC00); // 1 + -inf
    add_vec(1'b1, 16'h0001, 16'h3C00, 16'h0000); // subnormal flushed
    add_vec(1'b0, 16'h0001, 16'h3C00, 16'h3C00); // subnormal flushed
    add_vec(1'b0, 16'h4000, 16'hB800, 16'h3E00); // 2 - 0.5
    add_vec(1'b1, 16'h8400, 16'h0400, 16'h8000); // underflow, signed
    add_vec(1'b0, 16'h7BFF, 16'h7BFF, 16'h7C00); // add overflow
    add_vec(1'b1, 16'h3C01, 16'h3C01, 16'h3C02); // sticky only
    add_vec(1'b1, 16'hBC00, 16'h4200, 16'hC200); // -1 * 3
    add_vec(1'b0, 16'h4200, 16'hBC00, 16'h4000); // 3 - 1
    add_vec(1'b0, 16'h3C00, 16'hBC01, 16'h9400); // cancellation, LZC 10
`ifdef FP16_RNE_EN
    add_vec(1'b0, 16'h3C00, 16'h1200, 16'h3C01); // above half, round up
    add_vec(1'b1, 16'h3C01, 16'h3E00, 16'h3E02); // tie to even, up
`else
    add_vec(1'b0, 16'h3C00, 16'h1200, 16'h3C00); // truncated
    add_vec(1'b1, 16'h3C01, 16'h3E00, 16'h3E01); // truncated
`endif

    reset = 1'b1;
    en    = 1'b0;
    op    = 1'b0;
    a     = 16'h0000;
    b     = 16'h0000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check16("reset_result", result, 16'h0000);
    check1("reset_valid", valid, 1'b0);

    // Back-to-back: each negedge checks the previous vector and drives the next.
    for (int i = 0; i <= vecs.size(); i++) begin
      @(negedge clk);
      if (i > 0) begin
        check16($sformatf("vec%0d_result", i - 1), result, vecs[i-1].exp);
        check1($sformatf("vec%0d_valid", i - 1), valid, 1'b1);
      end
      if (i < vecs.size()) begin
        en = 1'b1;
        op = vecs[i].op;
        a  = vecs[i].a;
        b  = vecs[i].b;
      end else begin
        en = 1'b0;
      end
    end
    @(negedge clk);
    check1("idle_valid", valid, 1'b0);

    // Load 2.0, then hold with en low while inputs change.
    en = 1'b1;
    op = 1'b0;
    a  = 16'h3C00;
    b  = 16'h3C00;
    @(negedge clk);
    check16("load_result", result, 16'h4000);
    check1("load_valid", valid, 1'b1);
    en = 1'b0;
    a  = 16'h7C00;
    op = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check16($sformatf("hold%0d_result", k), result, 16'h4000);
      check1($sformatf("hold%0d_valid", k), valid, 1'b0);
      b = b + 16'h0100;
    end

    // Reset coinciding with en discards the operation.
    reset = 1'b1;
    en    = 1'b1;
    op    = 1'b1;
    a     = 16'h3C00;
    b     = 16'hBC00;
    @(negedge clk);
    check16("rst_en_result", result, 16'h0000);
    check1("rst_en_valid", valid, 1'b0);
    reset = 1'b0;
    en    = 1'b0;
    @(negedge clk);
    check16("post_rst_result", result, 16'h0000);
    check1("post_rst_valid", valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
